// File: rtl/s6_out_skid_if.sv
// s6 output-stage handshake bundle: upstream z side and downstream dout side.
// master = environment around the stage, slave = the skid stage itself.
interface s6_out_skid_if #(
    parameter int DATAWIDTH = 64
);
    logic [DATAWIDTH-1:0] z;
    logic                 z_valid;
    logic                 z_ready;
    logic [DATAWIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    modport master (
        output z, z_valid, dout_ready,
        input  z_ready, dout, dout_valid
    );

    modport slave (
        input  z, z_valid, dout_ready,
        output z_ready, dout, dout_valid
    );
endinterface

// File: rtl/s6_out_skid.sv
// s6 output stage: 2-entry skid buffer, registered valid/ready, delivered-word count.
// Define Z_ACCUM_EN to add the saturating running-sum accumulator (acc, acc_clr).
module s6_out_skid #(
    parameter int DATAWIDTH = 64,
    parameter int CNTWIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    s6_out_skid_if.slave        s6,
    output logic [CNTWIDTH-1:0] count
`ifdef Z_ACCUM_EN
    ,
    output logic [DATAWIDTH-1:0] acc,
    input  logic                 acc_clr
`endif
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_z_ready;
    logic                 r_dout_valid;
    logic [DATAWIDTH-1:0] r_main;
    logic [DATAWIDTH-1:0] r_skid;
    logic [CNTWIDTH-1:0]  r_count;

    logic w_accept;
    logic w_deliver;
    logic w_main_from_z;
    logic w_main_from_skid;
    logic w_skid_from_z;

    assign w_accept  = s6.z_valid & r_z_ready;
    assign w_deliver = r_dout_valid & s6.dout_ready;

    // ready/valid are registered copies of the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_z_ready    <= 1'b1;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_z_ready    <= (w_next != FULL);
            r_dout_valid <= (w_next != EMPTY);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            EMPTY: if (w_accept) w_next = ONE;
            ONE: begin
                if (w_accept && !w_deliver)
                    w_next = FULL;
                else if (!w_accept && w_deliver)
                    w_next = EMPTY;
            end
            FULL: if (w_deliver) w_next = ONE;
            default: w_next = EMPTY;
        endcase
    end

    always_comb begin
        w_main_from_z    = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_z    = 1'b0;
        unique case (r_state)
            EMPTY: w_main_from_z = w_accept;
            ONE: begin
                w_main_from_z = w_accept & w_deliver;
                w_skid_from_z = w_accept & ~w_deliver;
            end
            FULL: w_main_from_skid = w_deliver;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main  <= '0;
            r_skid  <= '0;
            r_count <= '0;
        end else begin
            if (w_main_from_z)
                r_main <= s6.z;
            else if (w_main_from_skid)
                r_main <= r_skid;
            if (w_skid_from_z)
                r_skid <= s6.z;
            if (w_deliver)
                r_count <= r_count + 1'b1;
        end
    end

    assign s6.z_ready    = r_z_ready;
    assign s6.dout_valid = r_dout_valid;
    assign s6.dout       = r_main;
    assign count         = r_count;

`ifdef Z_ACCUM_EN
    localparam logic [DATAWIDTH-1:0] ACC_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [DATAWIDTH-1:0] ACC_MIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

    logic [DATAWIDTH-1:0] r_acc;
    logic [DATAWIDTH:0]   w_sum;
    logic [DATAWIDTH-1:0] w_sat;

    // one guard bit: top two bits differ only on overflow
    assign w_sum = {r_acc[DATAWIDTH-1], r_acc}
                 + {r_main[DATAWIDTH-1], r_main};

    always_comb begin
        w_sat = w_sum[DATAWIDTH-1:0];
        if (w_sum[DATAWIDTH] != w_sum[DATAWIDTH-1])
            w_sat = w_sum[DATAWIDTH] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (acc_clr)
            r_acc <= w_deliver ? r_main : '0;
        else if (w_deliver)
            r_acc <= w_sat;
    end

    assign acc = r_acc;
`endif
endmodule

// File: tb/tb_s6_out_skid.sv
// Directed bench for s6_out_skid at DATAWIDTH=8, CNTWIDTH=4.
// Accumulator checks are active only when Z_ACCUM_EN is defined.
module tb_s6_out_skid;
    logic       clk;
    logic       rst;
    logic [3:0] count;
`ifdef Z_ACCUM_EN
    logic [7:0] acc;
    logic       acc_clr;
`endif

    int n_vec;
    int n_miss;

    s6_out_skid_if #(.DATAWIDTH(8)) ifc ();

    s6_out_skid #(
        .DATAWIDTH(8),
        .CNTWIDTH (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s6     (ifc.slave),
        .count  (count)
`ifdef Z_ACCUM_EN
        ,
        .acc    (acc),
        .acc_clr(acc_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        rst            = 1'b1;
        ifc.z          = '0;
        ifc.z_valid    = 1'b0;
        ifc.dout_ready = 1'b0;
`ifdef Z_ACCUM_EN
        acc_clr        = 1'b0;
`endif
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_zready", ifc.z_ready, 1);
        chk("rst_dvalid", ifc.dout_valid, 0);
        chk("rst_dout", $signed(ifc.dout), 0);
        chk("rst_count", count, 0);
`ifdef Z_ACCUM_EN
        chk("rst_acc", $signed(acc), 0);
`endif

        // streaming with consumer always ready
        ifc.dout_ready = 1'b1;
        ifc.z_valid    = 1'b1;
        ifc.z = 8'd5;
        tick;
        chk("s_d5", $signed(ifc.dout), 5);
        chk("s_v5", ifc.dout_valid, 1);
        ifc.z = -8'sd3;
        tick;
        chk("s_dm3", $signed(ifc.dout), -3);
        ifc.z = 8'd7;
        tick;
        chk("s_d7", $signed(ifc.dout), 7);
        ifc.z_valid = 1'b0;
        tick;
        chk("s_count", count, 3);
        chk("s_vdone", ifc.dout_valid, 0);
        chk("s_retain", $signed(ifc.dout), 7);
        chk("s_zready", ifc.z_ready, 1);
`ifdef Z_ACCUM_EN
        chk("s_acc", $signed(acc), 9);
`endif

        // backpressure fills both entries
        ifc.dout_ready = 1'b0;
        ifc.z_valid    = 1'b1;
        ifc.z = 8'd10;
        tick;
        chk("bp_zr1", ifc.z_ready, 1);
        chk("bp_d10", $signed(ifc.dout), 10);
        ifc.z = 8'd20;
        tick;
        chk("bp_full", ifc.z_ready, 0);
        ifc.z = 8'd30;
        tick;
        chk("bp_hold_d", $signed(ifc.dout), 10);
        chk("bp_hold_v", ifc.dout_valid, 1);
        chk("bp_hold_r", ifc.z_ready, 0);
        chk("bp_hold_c", count, 3);
        ifc.dout_ready = 1'b1;
        tick;
        chk("bp_d20", $signed(ifc.dout), 20);
        chk("bp_zr2", ifc.z_ready, 1);
        tick;
        chk("bp_d30", $signed(ifc.dout), 30);
        chk("bp_v30", ifc.dout_valid, 1);
        ifc.z_valid = 1'b0;
        tick;
        chk("bp_vdone", ifc.dout_valid, 0);
        chk("bp_count", count, 6);
`ifdef Z_ACCUM_EN
        chk("bp_acc", $signed(acc), 69);
        acc_clr = 1'b1;
`endif
        tick;
`ifdef Z_ACCUM_EN
        acc_clr = 1'b0;
        chk("clr_acc", $signed(acc), 0);
`endif

        // saturation at both ends
        ifc.z_valid = 1'b1;
        ifc.z = 8'd100;
        tick;
        tick;
        chk("sat_d100", $signed(ifc.dout), 100);
        ifc.z = -8'sd128;
        tick;
        chk("sat_dmin", $signed(ifc.dout), -128);
`ifdef Z_ACCUM_EN
        chk("sat_pos", $signed(acc), 127);
`endif
        ifc.z_valid = 1'b0;
        tick;
        chk("sat_cnt", count, 9);
`ifdef Z_ACCUM_EN
        chk("sat_m1", $signed(acc), -1);
`endif
        ifc.z_valid = 1'b1;
        tick;
        ifc.z_valid = 1'b0;
        tick;
        chk("sat_cnt2", count, 10);
`ifdef Z_ACCUM_EN
        chk("sat_neg", $signed(acc), -128);
`endif

        // clear coinciding with a delivery restarts at that word
        ifc.z_valid = 1'b1;
        ifc.z = 8'd42;
        tick;
        ifc.z_valid = 1'b0;
`ifdef Z_ACCUM_EN
        acc_clr = 1'b1;
`endif
        tick;
`ifdef Z_ACCUM_EN
        acc_clr = 1'b0;
        chk("clr_dlv", $signed(acc), 42);
`endif
        chk("clr_cnt", count, 11);

        // reset while FULL discards both entries
        ifc.dout_ready = 1'b0;
        ifc.z_valid    = 1'b1;
        ifc.z = 8'd1;
        tick;
        ifc.z = 8'd2;
        tick;
        chk("rf_full", ifc.z_ready, 0);
        ifc.z_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rf_dvalid", ifc.dout_valid, 0);
        chk("rf_zready", ifc.z_ready, 1);
        chk("rf_count", count, 0);
        chk("rf_dout", $signed(ifc.dout), 0);
`ifdef Z_ACCUM_EN
        chk("rf_acc", $signed(acc), 0);
`endif
        ifc.dout_ready = 1'b1;
        tick;
        tick;
        chk("rf_quiet", ifc.dout_valid, 0);
        chk("rf_cnt2", count, 0);

        // 17 deliveries wrap the 4-bit counter to 1
        ifc.z_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ifc.z = 8'(i);
            tick;
            chk("wr_dout", $signed(ifc.dout), i);
        end
        chk("wr_zero", count, 0);
        ifc.z_valid = 1'b0;
        tick;
        chk("wr_count", count, 1);
        chk("wr_vdone", ifc.dout_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
